// File: rtl/edubos5_pkg.sv
// ----------------------------------------------------------------------------
// edubos5_pkg
// Shared types for the eduBOS5 core: bus byte-enable encoding, load/store
// funct3 encodings, and the load/store unit FSM state and command record.
// No ports (package).
// ----------------------------------------------------------------------------
package edubos5_pkg;

   // Byte-enable patterns on the data bus; bit n enables byte lane n.
   typedef enum logic [3:0] {
      NOWR      = 4'b0000,
      BYTE1     = 4'b0001,
      BYTE2     = 4'b0010,
      BYTE3     = 4'b0100,
      BYTE4     = 4'b1000,
      HALFWORD1 = 4'b0011,
      HALFWORD2 = 4'b1100,
      WORD      = 4'b1111
   } we_bs_t;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } funct3_load_t;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } funct3_store_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } lsu_state_t;

   typedef struct packed {
      logic        load;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdat;
      logic [4:0]  rd;
   } lsu_cmd_t;

endpackage

// File: rtl/edubos5_lsu_align.sv
// ----------------------------------------------------------------------------
// edubos5_lsu_align
// Purely combinational data steering for the load/store unit.
//   load      in  1  : 1 = load, 0 = store
//   funct3    in  3  : load/store width encoding
//   addr_lsb  in  2  : byte offset within the word
//   wdat      in  32 : right-aligned store data
//   rdat      in  32 : raw bus read word
//   we        out 4  : byte enables (NOWR for loads and illegal commands)
//   wdat_lane out 32 : store data replicated onto every lane
//   rdat_ext  out 32 : extracted and sign/zero-extended load data
//   dec_err   out 1  : command cannot be issued to the bus
// Build option: EDUBOS5_MISALIGN_TRAP_EN turns misaligned halfword/word
// accesses into decode errors; otherwise the offending LSBs are ignored.
// ----------------------------------------------------------------------------
module edubos5_lsu_align
   import edubos5_pkg::*;
(
   input  logic        load,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lsb,
   input  logic [31:0] wdat,
   input  logic [31:0] rdat,
   output we_bs_t      we,
   output logic [31:0] wdat_lane,
   output logic [31:0] rdat_ext,
   output logic        dec_err
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic        illegal;
   logic        misalign;

   always_comb begin
      rd_byte   = 8'h00;
      rd_half   = addr_lsb[1] ? rdat[31:16] : rdat[15:0];
      we        = NOWR;
      wdat_lane = 32'h0;
      rdat_ext  = 32'h0;
      illegal   = 1'b0;
      misalign  = 1'b0;

      case (addr_lsb)
         2'd0:    rd_byte = rdat[7:0];
         2'd1:    rd_byte = rdat[15:8];
         2'd2:    rd_byte = rdat[23:16];
         default: rd_byte = rdat[31:24];
      endcase

      if (load) begin
         case (funct3)
            LB:  rdat_ext = {{24{rd_byte[7]}}, rd_byte};
            LBU: rdat_ext = {24'h0, rd_byte};
            LH: begin
               rdat_ext = {{16{rd_half[15]}}, rd_half};
               misalign = addr_lsb[0];
            end
            LHU: begin
               rdat_ext = {16'h0, rd_half};
               misalign = addr_lsb[0];
            end
            LW: begin
               rdat_ext = rdat;
               misalign = (addr_lsb != 2'd0);
            end
            default: illegal = 1'b1;
         endcase
      end else begin
         case (funct3)
            SB: begin
               wdat_lane = {4{wdat[7:0]}};
               case (addr_lsb)
                  2'd0:    we = BYTE1;
                  2'd1:    we = BYTE2;
                  2'd2:    we = BYTE3;
                  default: we = BYTE4;
               endcase
            end
            SH: begin
               wdat_lane = {2{wdat[15:0]}};
               we        = addr_lsb[1] ? HALFWORD2 : HALFWORD1;
               misalign  = addr_lsb[0];
            end
            SW: begin
               wdat_lane = wdat;
               we        = WORD;
               misalign  = (addr_lsb != 2'd0);
            end
            default: illegal = 1'b1;
         endcase
      end

      // An errored command never reaches the bus, so keep its lanes quiet.
      if (illegal) begin
         we        = NOWR;
         wdat_lane = 32'h0;
      end
   end

`ifdef EDUBOS5_MISALIGN_TRAP_EN
   assign dec_err = illegal | misalign;
`else
   logic misalign_unused;
   assign misalign_unused = misalign;
   assign dec_err         = illegal;
`endif

endmodule

// File: rtl/edubos5_lsu.sv
// ----------------------------------------------------------------------------
// edubos5_lsu
// Load/store unit: accepts one LOAD/STORE command at a time, drives a
// req/ack data bus with timeout, and returns extended load data or an error.
//   clk        in  1  : clock
//   arst       in  1  : asynchronous active-high reset
//   cmd_*      in     : command (vld/load/funct3/addr/wdat/rd), cmd_rdy out
//   rsp_*      out    : one-cycle response (vld/rdat/rd/err)
//   bus_*      out    : req/we/addr/wdat towards memory
//   bus_ack    in  1  : completion, read data valid the same cycle
//   bus_rdat   in  32 : read word
// Parameter TIMEOUT_CYC: max cycles of bus_req without ack (0 = no timeout).
// Build option: EDUBOS5_MISALIGN_TRAP_EN (see edubos5_lsu_align).
// ----------------------------------------------------------------------------
module edubos5_lsu
   import edubos5_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
)(
   input  logic        clk,
   input  logic        arst,
   input  logic        cmd_vld,
   output logic        cmd_rdy,
   input  logic        cmd_load,
   input  logic [2:0]  cmd_funct3,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdat,
   input  logic [4:0]  cmd_rd,
   output logic        rsp_vld,
   output logic [31:0] rsp_rdat,
   output logic [4:0]  rsp_rd,
   output logic        rsp_err,
   output logic        bus_req,
   output we_bs_t      bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdat,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdat
);

   localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   lsu_state_t    state_reg;
   lsu_cmd_t      cmd_reg;
   lsu_cmd_t      cmd_in;
   lsu_cmd_t      cmd_sel;
   logic [CW-1:0] tmo_cnt_reg;
   logic          tmo_hit;

   logic          bus_req_reg;
   we_bs_t        bus_we_reg;
   logic [31:0]   bus_addr_reg;
   logic [31:0]   bus_wdat_reg;
   logic          rsp_vld_reg;
   logic [31:0]   rsp_rdat_reg;
   logic [4:0]    rsp_rd_reg;
   logic          rsp_err_reg;

   we_bs_t        al_we;
   logic [31:0]   al_wdat_lane;
   logic [31:0]   al_rdat_ext;
   logic          al_dec_err;

   assign cmd_in = '{load:   cmd_load,
                     funct3: cmd_funct3,
                     addr:   cmd_addr,
                     wdat:   cmd_wdat,
                     rd:     cmd_rd};

   // While idle the aligner decodes the incoming command (lanes, errors);
   // afterwards it works on the captured command to extract load data.
   assign cmd_sel = (state_reg == IDLE) ? cmd_in : cmd_reg;

   edubos5_lsu_align u_align (
      .load      (cmd_sel.load),
      .funct3    (cmd_sel.funct3),
      .addr_lsb  (cmd_sel.addr[1:0]),
      .wdat      (cmd_sel.wdat),
      .rdat      (bus_rdat),
      .we        (al_we),
      .wdat_lane (al_wdat_lane),
      .rdat_ext  (al_rdat_ext),
      .dec_err   (al_dec_err)
   );

   // The counter holds the number of completed unacknowledged REQ cycles,
   // so the last allowed cycle is the one where count+1 equals the limit.
   assign tmo_hit = (TIMEOUT_CYC != 0) &&
                    ((32'(tmo_cnt_reg) + 32'd1) == 32'(TIMEOUT_CYC));

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_reg    <= IDLE;
         cmd_reg      <= '0;
         tmo_cnt_reg  <= '0;
         bus_req_reg  <= 1'b0;
         bus_we_reg   <= NOWR;
         bus_addr_reg <= 32'h0;
         bus_wdat_reg <= 32'h0;
         rsp_vld_reg  <= 1'b0;
         rsp_rdat_reg <= 32'h0;
         rsp_rd_reg   <= 5'h0;
         rsp_err_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (cmd_vld) begin
                  cmd_reg     <= cmd_in;
                  tmo_cnt_reg <= '0;
                  if (al_dec_err) begin
                     state_reg    <= RSP;
                     rsp_vld_reg  <= 1'b1;
                     rsp_err_reg  <= 1'b1;
                     rsp_rdat_reg <= 32'h0;
                     rsp_rd_reg   <= cmd_rd;
                  end else begin
                     state_reg    <= REQ;
                     bus_req_reg  <= 1'b1;
                     bus_we_reg   <= al_we;
                     bus_addr_reg <= {cmd_addr[31:2], 2'b00};
                     bus_wdat_reg <= al_wdat_lane;
                  end
               end
            end
            REQ: begin
               if (bus_ack || tmo_hit) begin
                  // Ack is tested first so it beats a coincident timeout.
                  state_reg    <= RSP;
                  bus_req_reg  <= 1'b0;
                  bus_we_reg   <= NOWR;
                  bus_addr_reg <= 32'h0;
                  bus_wdat_reg <= 32'h0;
                  rsp_vld_reg  <= 1'b1;
                  rsp_err_reg  <= ~bus_ack;
                  rsp_rdat_reg <= (bus_ack && cmd_reg.load) ? al_rdat_ext : 32'h0;
                  rsp_rd_reg   <= cmd_reg.rd;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
               end
            end
            RSP: begin
               state_reg    <= IDLE;
               rsp_vld_reg  <= 1'b0;
               rsp_err_reg  <= 1'b0;
               rsp_rdat_reg <= 32'h0;
               rsp_rd_reg   <= 5'h0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign cmd_rdy  = (state_reg == IDLE);
   assign bus_req  = bus_req_reg;
   assign bus_we   = bus_we_reg;
   assign bus_addr = bus_addr_reg;
   assign bus_wdat = bus_wdat_reg;
   assign rsp_vld  = rsp_vld_reg;
   assign rsp_rdat = rsp_rdat_reg;
   assign rsp_rd   = rsp_rd_reg;
   assign rsp_err  = rsp_err_reg;

endmodule

// File: tb/tb_edubos5_lsu.sv
// ----------------------------------------------------------------------------
// tb_edubos5_lsu
// Self-checking bench for edubos5_lsu (TIMEOUT_CYC = 4). Directed cases for
// the key lane/extension/timeout/reset behaviours, then randomized commands
// compared against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_edubos5_lsu;

   localparam int unsigned T = 4;

   logic        clk;
   logic        arst;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic        cmd_load;
   logic [2:0]  cmd_funct3;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdat;
   logic [4:0]  cmd_rd;
   logic        rsp_vld;
   logic [31:0] rsp_rdat;
   logic [4:0]  rsp_rd;
   logic        rsp_err;
   logic        bus_req;
   logic [3:0]  bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdat;
   logic        bus_ack;
   logic [31:0] bus_rdat;

   int n_cmp = 0;
   int n_mis = 0;

   edubos5_lsu #(.TIMEOUT_CYC(T)) dut (
      .clk        (clk),
      .arst       (arst),
      .cmd_vld    (cmd_vld),
      .cmd_rdy    (cmd_rdy),
      .cmd_load   (cmd_load),
      .cmd_funct3 (cmd_funct3),
      .cmd_addr   (cmd_addr),
      .cmd_wdat   (cmd_wdat),
      .cmd_rd     (cmd_rd),
      .rsp_vld    (rsp_vld),
      .rsp_rdat   (rsp_rdat),
      .rsp_rd     (rsp_rd),
      .rsp_err    (rsp_err),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdat   (bus_wdat),
      .bus_ack    (bus_ack),
      .bus_rdat   (bus_rdat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no end, required $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: what the bus and response should look like for a command,
   // computed from the lane/extension rules with plain arithmetic.
   task automatic model(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdv,
                        output bit err, output logic [3:0] we,
                        output logic [31:0] bwd, output logic [31:0] res);
      int unsigned off;
      logic [31:0] b;
      logic [31:0] h;
      bit mis;
      off = addr % 4;
      err = 0; mis = 0; we = 4'h0; bwd = 32'h0; res = 32'h0;
      b = (rdv >> (8 * off)) & 32'hFF;
      h = (rdv >> (16 * (off / 2))) & 32'hFFFF;
      if (ld) begin
         case (f3)
            3'd0: res = (b >= 32'd128) ? b - 32'd256 : b;
            3'd4: res = b;
            3'd1: begin res = (h >= 32'd32768) ? h - 32'd65536 : h; mis = (off % 2) != 0; end
            3'd5: begin res = h; mis = (off % 2) != 0; end
            3'd2: begin res = rdv; mis = off != 0; end
            default: err = 1;
         endcase
      end else begin
         case (f3)
            3'd0: begin bwd = (wd & 32'hFF) * 32'h01010101; we = 4'(1 << off); end
            3'd1: begin bwd = (wd & 32'hFFFF) * 32'h00010001; we = 4'(3 << (2 * (off / 2))); mis = (off % 2) != 0; end
            3'd2: begin bwd = wd; we = 4'hF; mis = off != 0; end
            default: err = 1;
         endcase
      end
`ifdef EDUBOS5_MISALIGN_TRAP_EN
      if (mis) err = 1;
`endif
      if (err) begin we = 4'h0; bwd = 32'h0; end
   endtask

   // One command from the idle negedge to the idle negedge after the response.
   // ack_dly = number of REQ cycles before ack; >= T means ack withheld.
   task automatic txn(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [4:0] rd,
                      input logic [31:0] rdv, input int ack_dly);
      bit err, tmo;
      logic [3:0] we;
      logic [31:0] bwd, res;
      int k;
      model(ld, f3, addr, wd, rdv, err, we, bwd, res);
      $display("txn %s f3=%0d addr=0x%08h wdat=0x%08h rd=%0d rdat=0x%08h ack_dly=%0d exp_err=%0b",
               ld ? "LOAD " : "STORE", f3, addr, wd, rd, rdv, ack_dly, err);
      check("cmd_rdy_idle", {31'h0, cmd_rdy}, 32'd1);
      cmd_vld = 1; cmd_load = ld; cmd_funct3 = f3; cmd_addr = addr; cmd_wdat = wd; cmd_rd = rd;
      @(posedge clk);
      @(negedge clk);
      cmd_vld = 0; cmd_addr = $urandom; cmd_wdat = $urandom; cmd_rd = 5'($urandom);
      tmo = 0;
      if (!err) begin
         k = 0;
         forever begin
            check("bus_req", {31'h0, bus_req}, 32'd1);
            check("cmd_rdy_busy", {31'h0, cmd_rdy}, 32'd0);
            check("bus_addr", bus_addr, addr - (addr % 4));
            check("bus_we", {28'h0, bus_we}, {28'h0, we});
            check("bus_wdat", bus_wdat, bwd);
            if (k == ack_dly) begin
               bus_ack = 1; bus_rdat = rdv;
               @(negedge clk);
               bus_ack = 0; bus_rdat = $urandom;
               break;
            end else if (k == int'(T) - 1) begin
               tmo = 1;
               @(negedge clk);
               break;
            end
            @(negedge clk);
            k++;
         end
      end
      check("bus_req_rsp", {31'h0, bus_req}, 32'd0);
      check("rsp_vld", {31'h0, rsp_vld}, 32'd1);
      check("rsp_err", {31'h0, rsp_err}, {31'h0, err | tmo});
      check("rsp_rdat", rsp_rdat, (err || tmo || !ld) ? 32'h0 : res);
      check("rsp_rd", {27'h0, rsp_rd}, {27'h0, rd});
      @(negedge clk);
      check("rsp_vld_pulse", {31'h0, rsp_vld}, 32'd0);
   endtask

   initial begin
      arst = 1; cmd_vld = 0; cmd_load = 0; cmd_funct3 = 0; cmd_addr = 0;
      cmd_wdat = 0; cmd_rd = 0; bus_ack = 0; bus_rdat = 0;
      repeat (2) @(negedge clk);
      check("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'd1);
      check("rst_bus_req", {31'h0, bus_req}, 32'd0);
      check("rst_rsp_vld", {31'h0, rsp_vld}, 32'd0);
      check("rst_bus_we", {28'h0, bus_we}, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_rsp_rdat", rsp_rdat, 32'd0);
      arst = 0;
      @(negedge clk);
      check("post_rst_cmd_rdy", {31'h0, cmd_rdy}, 32'd1);

      // Directed cases
      txn(0, 3'd2, 32'h100, 32'hDEADBEEF, 5'd1, 32'h0, 0);
      txn(1, 3'd0, 32'h103, 32'h0, 5'd2, 32'h80000000, 0);
      txn(1, 3'd4, 32'h103, 32'h0, 5'd3, 32'h80000000, 0);
      txn(0, 3'd1, 32'h102, 32'h00001234, 5'd4, 32'h0, 1);
      txn(1, 3'd1, 32'h102, 32'h0, 5'd5, 32'h80010000, 2);
      txn(1, 3'd2, 32'h101, 32'h0, 5'd6, 32'hCAFEF00D, 0);
      txn(1, 3'd6, 32'h200, 32'h0, 5'd7, 32'h0, 0);
      txn(0, 3'd3, 32'h200, 32'h55, 5'd8, 32'h0, 0);
      txn(1, 3'd2, 32'h300, 32'h0, 5'd9, 32'h12345678, 99);
      txn(1, 3'd2, 32'h304, 32'h0, 5'd10, 32'h87654321, int'(T) - 1);
      txn(0, 3'd0, 32'h401, 32'hA5, 5'd11, 32'h0, 0);

      // Asynchronous reset while a request is outstanding
      cmd_vld = 1; cmd_load = 1; cmd_funct3 = 3'd2; cmd_addr = 32'h500; cmd_rd = 5'd12;
      @(posedge clk);
      @(negedge clk);
      cmd_vld = 0;
      check("arst_pre_req", {31'h0, bus_req}, 32'd1);
      arst = 1;
      #1;
      check("arst_bus_req", {31'h0, bus_req}, 32'd0);
      check("arst_cmd_rdy", {31'h0, cmd_rdy}, 32'd1);
      @(negedge clk);
      arst = 0;
      bus_ack = 1; bus_rdat = 32'hFFFFFFFF;
      @(negedge clk);
      bus_ack = 0;
      check("late_ack_rsp_vld", {31'h0, rsp_vld}, 32'd0);
      check("late_ack_bus_req", {31'h0, bus_req}, 32'd0);
      @(negedge clk);
      check("late_ack_rsp_vld2", {31'h0, rsp_vld}, 32'd0);
      check("late_ack_cmd_rdy", {31'h0, cmd_rdy}, 32'd1);

      // Randomized commands
      for (int i = 0; i < 300; i++) begin
         txn(1'($urandom), 3'($urandom), 32'h1000 + 32'($urandom_range(0, 255)),
             $urandom, 5'($urandom), $urandom, int'($urandom_range(0, 5)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
